seg7_hc595_scanner: RTL and testbench

Downstream display stage for the SPI flash/MPU test flow. Accepts a 32-bit word (flash or MPU6000 data) and shows it as eight hex digits on multiplexed 7-segment indicators. The indicators are driven through two daisy-chained 74HC595 shift registers. The block scans continuously, one digit at a time, by serially shifting a 16-bit segment/digit-select word and pulsing the 595 latch.

---
 rtl/seg7_hc595_scanner_if.sv | 23 ++
 rtl/seg7_hc595_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_hc595_scanner.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_hc595_scanner_if.sv
// Display-side bundle: the captured word and strobes in, 74HC595 control pins out.
// The scanner takes the slave side; a producer or bench takes the master side.
interface seg7_hc595_scanner_if;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic        data_valid_i;
  logic        enable_i;
  logic        sr_sclk_o;
  logic        sr_wd_o;
  logic        sr_latch_o;
  logic        sr_oe_n_o;
  logic        frame_done_o;

  modport master (
    output data_i, dp_i, data_valid_i, enable_i,
    input  sr_sclk_o, sr_wd_o, sr_latch_o, sr_oe_n_o, frame_done_o
  );

  modport slave (
    input  data_i, dp_i, data_valid_i, enable_i,
    output sr_sclk_o, sr_wd_o, sr_latch_o, sr_oe_n_o, frame_done_o
  );
endinterface

// File: rtl/seg7_hc595_scanner.sv
// Scans a 32-bit word as eight hex digits through two chained 74HC595s, one digit per
// LOAD/SHIFT/LATCH/HOLD pass; all outputs registered, no backpressure (strobe, last wins).
module seg7_hc595_scanner #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned DIGIT_HOLD  = 1000,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          DIG_ACT_LOW = 1'b0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  seg7_hc595_scanner_if.slave disp
);

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_e;

  localparam logic [19:0] DIV_LAST  = 20'(CLK_DIV - 1);
  localparam logic [19:0] HOLD_LAST = (DIGIT_HOLD == 0) ? 20'd0 : 20'(DIGIT_HOLD - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] word_q, word_d;
  logic [31:0] pend_dat_q, pend_dat_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic [31:0] shad_dat_q, shad_dat_d;
  logic [7:0]  shad_dp_q, shad_dp_d;
  logic        sclk_q, sclk_d;
  logic        wd_q, wd_d;
  logic        latch_q, latch_d;
  logic        oe_n_q, oe_n_d;
  logic        fd_q, fd_d;
  logic        shown_q, shown_d;

  logic [31:0] cur_dat;
  logic [7:0]  cur_dp;
  logic [3:0]  nib;
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic [15:0] w;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit 0 reads the pending word (or the coinciding strobe) so a whole frame comes
  // from one snapshot; other digits read the shadow taken at that point.
  always_comb begin
    cur_dat = shad_dat_q;
    cur_dp  = shad_dp_q;
    if (idx_q == 3'd0) begin
      cur_dat = disp.data_valid_i ? disp.data_i : pend_dat_q;
      cur_dp  = disp.data_valid_i ? disp.dp_i   : pend_dp_q;
    end
    nib = cur_dat[{idx_q, 2'b00} +: 4];
    seg = {cur_dp[idx_q], seg7_decode(nib)} ^ {8{SEG_ACT_LOW}};
    dig = (8'd1 << idx_q) ^ {8{DIG_ACT_LOW}};
    w   = {dig, seg};
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    word_d     = word_q;
    pend_dat_d = pend_dat_q;
    pend_dp_d  = pend_dp_q;
    shad_dat_d = shad_dat_q;
    shad_dp_d  = shad_dp_q;
    sclk_d     = sclk_q;
    wd_d       = wd_q;
    latch_d    = latch_q;
    shown_d    = shown_q;
    fd_d       = 1'b0;

    if (disp.data_valid_i) begin
      pend_dat_d = disp.data_i;
      pend_dp_d  = disp.dp_i;
    end

    case (state_q)
      S_LOAD: begin
        if (idx_q == 3'd0) begin
          shad_dat_d = cur_dat;
          shad_dp_d  = cur_dp;
        end
        word_d  = w;
        bit_d   = 4'd15;
        wd_d    = w[15];
        sclk_d  = 1'b0;
        cnt_d   = 20'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 20'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            sclk_d  = 1'b0;
            latch_d = 1'b1;
            state_d = S_LATCH;
          end else begin
            // Data moves only at the start of a low phase, a full CLK_DIV before the rise.
            sclk_d = 1'b0;
            bit_d  = bit_q - 4'd1;
            wd_d   = word_q[bit_q - 4'd1];
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 20'd0;
          latch_d = 1'b0;
          shown_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 20'd0;
          idx_d   = idx_q + 3'd1;
          fd_d    = (idx_q == 3'd7);
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
    endcase

    // Outputs stay dark until a complete word has reached the 595 storage register.
    oe_n_d = ~(disp.enable_i & shown_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LOAD;
      idx_q      <= 3'd0;
      cnt_q      <= 20'd0;
      bit_q      <= 4'd15;
      word_q     <= 16'd0;
      pend_dat_q <= 32'd0;
      pend_dp_q  <= 8'd0;
      shad_dat_q <= 32'd0;
      shad_dp_q  <= 8'd0;
      sclk_q     <= 1'b0;
      wd_q       <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      fd_q       <= 1'b0;
      shown_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      pend_dat_q <= pend_dat_d;
      pend_dp_q  <= pend_dp_d;
      shad_dat_q <= shad_dat_d;
      shad_dp_q  <= shad_dp_d;
      sclk_q     <= sclk_d;
      wd_q       <= wd_d;
      latch_q    <= latch_d;
      oe_n_q     <= oe_n_d;
      fd_q       <= fd_d;
      shown_q    <= shown_d;
    end
  end

  assign disp.sr_sclk_o    = sclk_q;
  assign disp.sr_wd_o      = wd_q;
  assign disp.sr_latch_o   = latch_q;
  assign disp.sr_oe_n_o    = oe_n_q;
  assign disp.frame_done_o = fd_q;

endmodule

// File: tb/tb_seg7_hc595_scanner.sv
// Bench for seg7_hc595_scanner: two instances (normal and inverted polarity / zero hold)
// checked each cycle against a timing/content model derived from the digit schedule.
module tb_seg7_hc595_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        dv;
  logic        en;

  always #5 clk = ~clk;

  seg7_hc595_scanner_if ifa ();
  seg7_hc595_scanner_if ifb ();

  assign ifa.data_i = data;
  assign ifa.dp_i = dp;
  assign ifa.data_valid_i = dv;
  assign ifa.enable_i = en;
  assign ifb.data_i = data;
  assign ifb.dp_i = dp;
  assign ifb.data_valid_i = dv;
  assign ifb.enable_i = en;

  seg7_hc595_scanner #(.CLK_DIV(2), .DIGIT_HOLD(4), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0))
    dut_a (.clk_i(clk), .rst_ni(rst_n), .disp(ifa));
  seg7_hc595_scanner #(.CLK_DIV(1), .DIGIT_HOLD(0), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1))
    dut_b (.clk_i(clk), .rst_ni(rst_n), .disp(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  // Edge count since reset release: edge 1 is the first LOAD.
  int ecount = 0;
  logic en_edge = 1'b1;
  int          s_e [$];
  logic [31:0] s_d [$];
  logic [7:0]  s_p [$];

  logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [15:0] lw [2][64];
  int          nlat [2];
  logic [15:0] chain [2];
  logic        sclk_prev [2];
  logic        latch_prev [2];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t edge=%0d: got %h want %h", name, $time, ecount, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecount = 0;
      s_e.delete();
      s_d.delete();
      s_p.delete();
    end else begin
      ecount = ecount + 1;
      en_edge = en;
      if (dv) begin
        s_e.push_back(ecount);
        s_d.push_back(data);
        s_p.push_back(dp);
      end
    end
  end

  function automatic logic [15:0] word_of(input logic [31:0] d, input logic [7:0] q,
                                          input int k, input bit sa, input bit da);
    logic [3:0] nb;
    logic [7:0] sg;
    logic [7:0] dg;
    nb = 4'(d >> (4 * k));
    sg = {q[k], DEC[nb]};
    dg = 8'(1 << k);
    if (sa) sg = ~sg;
    if (da) dg = ~dg;
    return {dg, sg};
  endfunction

  // Frame f shows the last strobe captured at or before its digit-0 LOAD edge.
  function automatic logic [15:0] model_word(input int n, input int dpd, input bit sa, input bit da);
    int f;
    int l0;
    logic [31:0] d;
    logic [7:0] q;
    f = n / 8;
    l0 = 1 + 8 * f * dpd;
    d = 32'd0;
    q = 8'd0;
    foreach (s_e[i]) if (s_e[i] <= l0) begin
      d = s_d[i];
      q = s_p[i];
    end
    return word_of(d, q, n % 8, sa, da);
  endfunction

  task automatic check_cycle(input int id, input int c, input int h, input bit sa, input bit da,
                             input logic sclk, input logic wd, input logic latch,
                             input logic oe_n, input logic fd);
    int dpd;
    int p;
    int n;
    logic [15:0] w;
    logic e_sclk;
    logic e_latch;
    logic e_fd;
    logic e_oe;
    if (ecount == 0) begin
      cmp($sformatf("reset_outs%0d", id), 32'({sclk, wd, latch, oe_n, fd}), 32'h2);
      chain[id] = 16'd0;
      sclk_prev[id] = 1'b0;
      latch_prev[id] = 1'b0;
      nlat[id] = 0;
      return;
    end
    dpd = 1 + 33 * c + ((h == 0) ? 1 : h);
    p = (ecount - 1) % dpd;
    n = (ecount - 1) / dpd;
    w = model_word(n, dpd, sa, da);
    e_sclk = (p < 32 * c) && (((p / c) % 2) == 1);
    e_latch = (p >= 32 * c) && (p < 33 * c);
    e_fd = (ecount % (8 * dpd)) == 0;
    e_oe = !(en_edge && (ecount >= 1 + 33 * c));
    cmp($sformatf("ctl%0d{sclk,latch,oe_n,fd}", id), 32'({sclk, latch, oe_n, fd}),
        32'({e_sclk, e_latch, e_oe, e_fd}));
    if (p < 32 * c) cmp($sformatf("wd%0d", id), 32'(wd), 32'(w[15 - p / (2 * c)]));
    if (sclk && !sclk_prev[id]) chain[id] = {chain[id][14:0], wd};
    if (latch && !latch_prev[id]) begin
      cmp($sformatf("latch_word%0d", id), 32'(chain[id]), 32'(w));
      if (nlat[id] < 64) lw[id][nlat[id]] = chain[id];
      nlat[id]++;
    end
    sclk_prev[id] = sclk;
    latch_prev[id] = latch;
  endtask

  always @(negedge clk) begin
    check_cycle(0, 2, 4, 1'b0, 1'b0, ifa.sr_sclk_o, ifa.sr_wd_o, ifa.sr_latch_o,
                ifa.sr_oe_n_o, ifa.frame_done_o);
    check_cycle(1, 1, 0, 1'b1, 1'b1, ifb.sr_sclk_o, ifb.sr_wd_o, ifb.sr_latch_o,
                ifb.sr_oe_n_o, ifb.frame_done_o);
  end

  task automatic wait_until(input int e);
    while (ecount < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_at(input int e, input logic [31:0] d, input logic [7:0] q);
    wait_until(e - 1);
    data = d;
    dp = q;
    dv = 1'b1;
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic reset_with_bypass(input logic [31:0] d, input logic [7:0] q);
    rst_n = 1'b0;
    data = d;
    dp = q;
    dv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sr;
    logic okh;
    logic ps;
    rst_n = 1'b1;
    dv = 1'b0;
    en = 1'b1;
    data = 32'd0;
    dp = 8'd0;
    #1 rst_n = 1'b0;

    cmp("model_0x1234ABCD_d0", 32'(word_of(32'h1234ABCD, 8'h00, 0, 1'b0, 1'b0)), 32'h015E);
    cmp("model_0x1234ABCD_d1", 32'(word_of(32'h1234ABCD, 8'h00, 1, 1'b0, 1'b0)), 32'h0239);
    cmp("model_0x1234ABCD_d7", 32'(word_of(32'h1234ABCD, 8'h00, 7, 1'b0, 1'b0)), 32'h8006);
    cmp("model_zero_d0", 32'(word_of(32'h0, 8'h00, 0, 1'b0, 1'b0)), 32'h013F);
    cmp("model_pol_dp", 32'(word_of(32'h8, 8'h01, 0, 1'b1, 1'b1)), 32'hFE00);
    cmp("model_E_d0", 32'(word_of(32'hE, 8'h00, 0, 1'b0, 1'b0)), 32'h0179);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame and tearing (digit period 71, frame 568 on instance A).
    strobe_at(10, 32'h1234ABCD, 8'h00);
    strobe_at(1360, 32'hFFFFFFFF, 8'h00);
    strobe_at(1500, 32'h11111111, 8'h00);

    wait_until(1700);
    en = 1'b0;
    sr = 0;
    okh = 1'b1;
    ps = ifa.sr_sclk_o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i > 0 && ifa.sr_oe_n_o !== 1'b1) okh = 1'b0;
      if (ifa.sr_sclk_o && !ps) sr++;
      ps = ifa.sr_sclk_o;
    end
    en = 1'b1;
    cmp("blank_oe_high", 32'(okh), 32'd1);
    cmp("blank_sclk_runs", 32'(sr > 0), 32'd1);

    wait_until(1950);
    cmp("a_f0_d0", 32'(lw[0][0]), 32'h013F);
    cmp("a_f1_d0", 32'(lw[0][8]), 32'h015E);
    cmp("a_f1_d1", 32'(lw[0][9]), 32'h0239);
    cmp("a_f1_d7", 32'(lw[0][15]), 32'h8006);
    cmp("a_tear_f2_d7_old", 32'(lw[0][23]), 32'h8006);
    cmp("a_tear_f3_d0_low", 32'(lw[0][24][7:0]), 32'h06);
    cmp("a_tear_f3_d2", 32'(lw[0][26]), 32'h0406);
    cmp("b_f0_d0", 32'(lw[1][0]), 32'hFEC0);

    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = $urandom_range(400, 20);
      en = ($urandom_range(3, 0) != 0);
      strobe_at(ecount + gap, $urandom, 8'($urandom));
    end
    en = 1'b1;
    wait_until(ecount + 600);

    // Reset in the middle of a digit's shift, then a bypass strobe on the first LOAD.
    while (((ecount - 1) % 71) != 20) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_shift_a", 32'({ifa.sr_sclk_o, ifa.sr_wd_o, ifa.sr_latch_o, ifa.sr_oe_n_o,
                                ifa.frame_done_o}), 32'h2);
    cmp("rst_mid_shift_b", 32'({ifb.sr_sclk_o, ifb.sr_wd_o, ifb.sr_latch_o, ifb.sr_oe_n_o,
                                ifb.frame_done_o}), 32'h2);
    reset_with_bypass(32'h00000008, 8'h01);
    wait_until(80);
    cmp("a_bypass_8_dp", 32'(lw[0][0]), 32'h01FF);
    cmp("b_pol_8_dp", 32'(lw[1][0]), 32'hFE00);

    reset_with_bypass(32'h0000000E, 8'h00);
    wait_until(80);
    cmp("a_bypass_E", 32'(lw[0][0]), 32'h0179);
    cmp("a_latches_after_reset", 32'(nlat[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
